// File: rtl/alu_pkg.sv
// Shared definitions for the ALU opcode-sweep controller: width defaults,
// opcode range limits and the controller state encoding.
package alu_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_OP_W   = 4;
    localparam int unsigned OP_MIN     = 0;
    localparam int unsigned OP_MAX     = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/alu_sweep_ctrl.sv
// Steps a combinational ALU through an opcode range for one latched operand
// pair and streams each {opcode, result} downstream over valid/ready.
module alu_sweep_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned OP_W     = DEF_OP_W,
    parameter int unsigned FIRST_OP = OP_MIN,
    parameter int unsigned LAST_OP  = OP_MAX,
    parameter int unsigned SETTLE   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_cl,
    input  logic [DATA_W-1:0] alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OP_W-1:0]   res_cl,
    output logic [DATA_W-1:0] res_data
);

    localparam int unsigned      CNT_W    = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [OP_W-1:0]  FIRST_CL = OP_W'(FIRST_OP);
    localparam logic [OP_W-1:0]  LAST_CL  = OP_W'(LAST_OP);

    if (FIRST_OP > LAST_OP || LAST_OP > (2 ** OP_W) - 1) begin : g_bad_range
        $error("alu_sweep_ctrl: opcode range FIRST_OP..LAST_OP is invalid");
    end
    if (SETTLE < 1) begin : g_bad_settle
        $error("alu_sweep_ctrl: SETTLE must be at least 1");
    end

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic [DATA_W-1:0] alu_a_q,     alu_a_d;
    logic [DATA_W-1:0] alu_b_q,     alu_b_d;
    logic [OP_W-1:0]   alu_cl_q,    alu_cl_d;
    logic              res_valid_q, res_valid_d;
    logic [OP_W-1:0]   res_cl_q,    res_cl_d;
    logic [DATA_W-1:0] res_data_q,  res_data_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cl_d    = alu_cl_q;
        res_valid_d = res_valid_q;
        res_cl_d    = res_cl_q;
        res_data_d  = res_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    alu_a_d  = a_in;
                    alu_b_d  = b_in;
                    alu_cl_d = FIRST_CL;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // The edge on which the count reaches SETTLE is the capture edge.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    res_data_d  = alu_out;
                    res_cl_d    = alu_cl_q;
                    res_valid_d = 1'b1;
                    state_d     = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (alu_cl_q == LAST_CL) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        alu_cl_d = alu_cl_q + 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cl_q    <= '0;
            res_valid_q <= 1'b0;
            res_cl_q    <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cl_q    <= alu_cl_d;
            res_valid_q <= res_valid_d;
            res_cl_q    <= res_cl_d;
            res_data_q  <= res_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cl    = alu_cl_q;
    assign res_valid = res_valid_q;
    assign res_cl    = res_cl_q;
    assign res_data  = res_data_q;

endmodule

// File: doc/alu_sweep_ctrl.md
Name: alu_sweep_ctrl

Overview:
Sequential initiator for the 8-bit combinational ALU (operands a/b, 4-bit opcode cl, 8-bit out).
- On a start pulse it latches one operand pair and steps the ALU through an opcode range, one opcode at a time.
- After a settle delay it captures each ALU result and hands it downstream as {opcode, result} over a valid/ready interface.
- It is the hardware counterpart of the bench-driven opcode sweep, used for on-chip ALU self-test and result streaming.

Parameters:
DATA_W, 8, ALU operand/result width
OP_W, 4, opcode width
FIRST_OP, 0, first opcode issued
LAST_OP, 15, last opcode issued (FIRST_OP <= LAST_OP <= 2^OP_W-1; elaboration error otherwise)
SETTLE, 1, cycles alu_* held stable before capture (>=1)

Ports:
clk  in  1  rising-edge clock, sole clock
rst  in  1  synchronous, active-high reset
start  in  1  begin a sweep; honoured only in IDLE
a_in  in  DATA_W  operand A, latched on accepted start
b_in  in  DATA_W  operand B, latched on accepted start
busy  out  1  high from the cycle after an accepted start until the DONE cycle inclusive
done  out  1  one-cycle pulse after the last result transfers
alu_a  out  DATA_W  to ALU a
alu_b  out  DATA_W  to ALU b
alu_cl  out  OP_W  to ALU cl
alu_out  in  DATA_W  from ALU out
res_valid  out  1  result available
res_ready  in  1  downstream accepts
res_cl  out  OP_W  opcode of presented result
res_data  out  DATA_W  captured ALU result

Behaviour:
- All outputs are registered. On rst (any state, including mid-sweep): state IDLE; busy, done, res_valid = 0; alu_a, alu_b, alu_cl, res_cl, res_data = 0; settle counter = 0. Any in-flight result is dropped.
- IDLE: start=1 at edge N latches alu_a<=a_in, alu_b<=b_in, alu_cl<=FIRST_OP, clears the counter, goes to SETTLE. start=0 keeps IDLE. Changes on a_in/b_in are ignored at all times except the accepting edge.
- SETTLE: the counter increments each cycle. On the edge where the count reaches SETTLE: res_data<=alu_out, res_cl<=alu_cl, res_valid<=1, go to PRESENT.
  - Capture edge for the first opcode is N+SETTLE. With SETTLE=1, res_valid is first high in cycle N+2.
- PRESENT: res_valid, res_cl and res_data are held stable until res_valid&res_ready at an edge. On that transfer edge, res_valid<=0, then:
  - if alu_cl==LAST_OP: go to DONE.
  - else: alu_cl<=alu_cl+1, counter cleared, go to SETTLE.
- Throughput with res_ready tied high: one result per SETTLE+1 cycles.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE (busy=0). The opcode never wraps past LAST_OP; with LAST_OP=15 the 4-bit counter is not incremented to 0.
- start while busy is ignored and does not restart or queue. start in the DONE cycle is also ignored; a new sweep begins only from IDLE.
- res_ready held low stalls indefinitely in PRESENT. alu_* stay stable and there is no timeout.
- FIRST_OP==LAST_OP: exactly one result, then DONE.
- No arithmetic is performed here except the opcode increment (OP_W bits) and the settle counter (clog2(SETTLE+1) bits).

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W and OP_W defaults;
  - the state encoding enum {IDLE, SETTLE, PRESENT, DONE} (2 bits);
  - opcode constants OP_MIN=0 and OP_MAX=15.
- No sub-module needed. The FSM, counter and output registers form one flat module.
- The bench instantiates the existing ALU between alu_* and alu_out.

Test Plan:
- Full sweep: rst 2 cycles; a_in=100, b_in=50, start 1 cycle, res_ready=1, stub ALU out=(a^b)+cl. Required: 16 transfers, res_cl 0..15 with res_data 86..101 in order; first res_valid 2 cycles after start; done pulse exactly once; busy low afterwards.
- Backpressure: same stimulus, res_ready low for 5 cycles on opcode 3. Required: res_valid, res_cl=3 and res_data=89 held constant through the stall; no opcode skipped or duplicated.
- Start while busy: pulse start with a_in=7 during opcode 6. Required: ignored; remaining results still use a=100, b=50; only one done pulse.
- Reset mid-sweep: assert rst while in PRESENT with opcode 9. Required: next cycle all outputs 0, state IDLE; a new start with a_in=1, b_in=2 restarts at opcode 0 with res_data=3.
- Range/settle params: FIRST_OP=LAST_OP=15, SETTLE=3, a_in=255, b_in=0. Required: single result (res_cl=15, res_data=14 mod 256) with res_valid first high 4 cycles after start; done follows; no wrap to opcode 0.
